// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the decimated-rate blocks: default sample
// width and decimation, derived accumulator width, rounding constant and
// the sample type.
package dsp_pkg;

  localparam int unsigned DEF_IN_W     = 12;
  localparam int unsigned DEF_DEC_LOG2 = 2;

  // Accumulator holds a full block of N samples without overflow.
  localparam int unsigned ACC_W   = DEF_IN_W + DEF_DEC_LOG2;
  // Half an LSB of the decimated result, added before the shift.
  localparam int unsigned ROUND_K = 1 << (DEF_DEC_LOG2 - 1);

  typedef logic signed [DEF_IN_W-1:0] sample_t;

  // Rounding constant for an arbitrary decimation exponent (dec_log2 >= 1).
  function automatic int unsigned round_k(input int unsigned dec_log2);
    return 32'd1 << (dec_log2 - 1);
  endfunction

  // Accumulator width for a given sample width and decimation exponent.
  function automatic int unsigned acc_w(input int unsigned in_w,
                                        input int unsigned dec_log2);
    return in_w + dec_log2;
  endfunction

endpackage

// File: rtl/avg_round_shift.sv
// Rounded block mean: (sum + 2**(DEC_LOG2-1)) >>> DEC_LOG2, truncated to
// IN_W. Round half toward +inf. Purely combinational.
// Ports:
//   sum_i   signed block sum, IN_W+DEC_LOG2 bits
//   mean_c  signed rounded mean, IN_W bits
module avg_round_shift
  import dsp_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned DEC_LOG2 = DEF_DEC_LOG2
) (
  input  logic [acc_w(IN_W, DEC_LOG2)-1:0] sum_i,
  output logic [IN_W-1:0]                  mean_c
);

  localparam int unsigned SUM_W = acc_w(IN_W, DEC_LOG2);
  localparam int unsigned RND_K = round_k(DEC_LOG2);

  // One guard bit so the rounding add can never wrap.
  logic signed [SUM_W:0] biased_c;
  logic signed [SUM_W:0] shifted_c;

  always_comb begin
    biased_c  = signed'({sum_i[SUM_W-1], sum_i}) + signed'((SUM_W+1)'(RND_K));
    shifted_c = biased_c >>> DEC_LOG2;
    mean_c    = shifted_c[IN_W-1:0];
  end

  // Upper bits of the shifted value are pure sign extension of the result.
  logic unused_c;
  assign unused_c = ^shifted_c[SUM_W:IN_W];

endmodule

// File: rtl/avg_decimator.sv
// Accumulate-and-dump decimator: sums 2**DEC_LOG2 valid samples and emits
// one rounded mean per block through a single valid/ready holding register.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   in_valid     x_in carries a new sample this cycle
//   x_in         signed input sample
//   out_data     signed rounded block mean (registered)
//   out_valid    out_data holds an unconsumed result (registered)
//   out_ready    consumer takes out_data when out_valid && out_ready
//   overrun      one-cycle pulse: an unconsumed result was overwritten
module avg_decimator
  import dsp_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned DEC_LOG2 = DEF_DEC_LOG2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [IN_W-1:0] x_in,
  output logic [IN_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun
);

  localparam int unsigned SUM_W = acc_w(IN_W, DEC_LOG2);
  localparam int unsigned N     = 1 << DEC_LOG2;

  localparam logic [DEC_LOG2-1:0] PHASE_LAST = DEC_LOG2'(N - 1);
  localparam logic [DEC_LOG2-1:0] PHASE_ONE  = DEC_LOG2'(1);

  logic [DEC_LOG2-1:0] phase_q, phase_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [IN_W-1:0]     out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;

  logic [SUM_W-1:0]    x_ext_c;
  logic [SUM_W-1:0]    sum_c;
  logic [IN_W-1:0]     mean_c;
  logic                dump_c;
  logic                take_c;

  // Sign-extended sample and the running sum including this sample.
  always_comb begin
    x_ext_c = {{DEC_LOG2{x_in[IN_W-1]}}, x_in};
    sum_c   = acc_q + x_ext_c;
  end

  avg_round_shift #(
    .IN_W     (IN_W),
    .DEC_LOG2 (DEC_LOG2)
  ) u_round (
    .sum_i  (sum_c),
    .mean_c (mean_c)
  );

  // Phase counter and accumulator; phase wraps naturally at N.
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    dump_c  = in_valid && (phase_q == PHASE_LAST);
    if (in_valid) begin
      phase_d = phase_q + PHASE_ONE;
      acc_d   = (phase_q == '0) ? x_ext_c : sum_c;
    end
  end

  // Output holding register with handshake and overrun detection.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    take_c      = out_valid_q && out_ready;
    if (take_c) begin
      out_valid_d = 1'b0;
    end
    if (dump_c) begin
      out_data_d  = mean_c;
      out_valid_d = 1'b1;
      // A simultaneous transfer frees the register, so only a blocked
      // result counts as overwritten.
      overrun_d   = out_valid_q && !out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_avg_decimator.sv
module tb_avg_decimator;

  localparam int IN_W     = 12;
  localparam int DEC_LOG2 = 2;
  localparam int N        = 1 << DEC_LOG2;

  logic                   clk;
  logic                   resetn;
  logic                   in_valid;
  logic signed [IN_W-1:0] x_in;
  logic signed [IN_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overrun;

  int n_cmp;
  int n_bad;

  // Reference state: samples collected in the current block and the
  // expected registered outputs.
  int blk[$];
  int exp_data;
  int exp_valid;
  int exp_ovr;

  avg_decimator #(.IN_W(IN_W), .DEC_LOG2(DEC_LOG2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (act === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Mean of a block: floor((sum + N/2) / N), computed with plain integers.
  function automatic int block_mean(input int s[$]);
    int sum;
    int num;
    int q;
    sum = 0;
    foreach (s[i]) sum += s[i];
    num = sum + N / 2;
    q = num / N;
    if ((num % N != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  // Apply inputs for one clock, advance the reference, check all outputs.
  task automatic step(input logic rn, input logic v, input int x, input logic rdy);
    int nv;
    resetn    = rn;
    in_valid  = v;
    x_in      = IN_W'(x);
    out_ready = rdy;
    @(posedge clk);
    if (!rn) begin
      blk.delete();
      exp_data  = 0;
      exp_valid = 0;
      exp_ovr   = 0;
    end else begin
      exp_ovr = 0;
      nv = (exp_valid != 0 && rdy) ? 0 : exp_valid;
      if (v) begin
        blk.push_back(int'(x_in));
        if (blk.size() == N) begin
          if (exp_valid != 0 && !rdy) exp_ovr = 1;
          exp_data = block_mean(blk);
          nv = 1;
          blk.delete();
        end
      end
      exp_valid = nv;
    end
    #1;
    chk("out_valid", 32'(out_valid), exp_valid);
    chk("overrun", 32'(overrun), exp_ovr);
    if (exp_valid != 0 || !rn) chk("out_data", out_data, exp_data);
  endtask

  task automatic samples(input int x, input int cnt, input logic rdy);
    for (int i = 0; i < cnt; i++) step(1'b1, 1'b1, x, rdy);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_data = 0;
    exp_valid = 0;
    exp_ovr = 0;
    resetn = 1'b0;
    in_valid = 1'b0;
    x_in = '0;
    out_ready = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 77, 1'b1);
    chk("reset_data", out_data, 0);

    // Constant input, continuous strobes, ready high
    samples(4, 16, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);

    // Rounding and sign handling
    step(1'b1, 1'b1, 1, 1'b1);
    step(1'b1, 1'b1, 2, 1'b1);
    step(1'b1, 1'b1, 3, 1'b1);
    step(1'b1, 1'b1, 4, 1'b1);
    chk("mean_1234", out_data, 3);
    step(1'b1, 1'b1, -1, 1'b1);
    step(1'b1, 1'b1, -2, 1'b1);
    step(1'b1, 1'b1, -2, 1'b1);
    step(1'b1, 1'b1, -2, 1'b1);
    chk("mean_neg", out_data, -2);

    // Gapped strobes, five cycles apart
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, k, 1'b1);
      for (int g = 0; g < 4; g++) step(1'b1, 1'b0, 999, 1'b1);
    end

    // Extremes
    samples(2047, 4, 1'b1);
    chk("mean_max", out_data, 2047);
    samples(-2048, 4, 1'b1);
    chk("mean_min", out_data, -2048);
    step(1'b1, 1'b0, 0, 1'b1);

    // Backpressure and overrun
    samples(5, 8, 1'b0);
    samples(9, 8, 1'b0);
    for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 0, 1'b0);
    chk("held_data", out_data, 9);
    step(1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);

    // Simultaneous accept and dump
    samples(7, 4, 1'b0);
    samples(3, 3, 1'b0);
    step(1'b1, 1'b1, 3, 1'b1);
    chk("simul_valid", 32'(out_valid), 1);
    chk("simul_ovr", 32'(overrun), 0);
    step(1'b1, 1'b0, 0, 1'b1);

    // Reset mid-block
    samples(100, 2, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    samples(8, 4, 1'b1);
    chk("after_reset", out_data, 8);
    step(1'b1, 1'b0, 0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rn;
      logic v;
      logic rdy;
      int x;
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: x = 2047;
        1: x = -2048;
        default: x = int'($urandom_range(0, 4095)) - 2048;
      endcase
      step(rn, v, x, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
